// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Latency: N+2 cycles (N = DATA_WIDTH/BITS_PER_CYCLE); divide-by-zero and signed overflow take a 1-edge fast path.
// Backpressure: single op in flight; result held in DONE until out_ready_i; in_ready_o only in IDLE.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   in_valid_i/in_ready_o         request handshake (op_i, a_i, b_i latched on accept)
//   flush_i                       abort any in-flight op, drop a pending result
//   out_valid_o/out_ready_i       result handshake (res_o)
//   busy_o                        unit not idle
module muldiv_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  busy_o
);

  localparam int W  = DATA_WIDTH;
  localparam int B  = BITS_PER_CYCLE;
  localparam int N  = W / B;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc;    // multiply: {partial high, multiplier}; divide: {remainder, dividend/quotient}
  logic [W-1:0]    opb;    // multiplicand or divisor magnitude
  logic [2:0]      op_q;
  logic            neg_q;  // final result must be negated

  // ---------------- request decode ----------------
  logic         a_sgn, b_sgn, a_neg, b_neg, neg_in;
  logic         b_zero, ovf, fast, accept, handoff;
  logic [W-1:0] a_mag, b_mag, fast_res;

  assign in_ready_o = (state == IDLE) && !rst_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign handoff    = (state == DONE) && out_valid_o && out_ready_i;

  assign a_sgn  = !(op_i == 3'b011 || op_i == 3'b101 || op_i == 3'b111);
  assign b_sgn  = (op_i == 3'b000 || op_i == 3'b001 || op_i == 3'b100 || op_i == 3'b110);
  assign a_neg  = a_sgn && a_i[W-1];
  assign b_neg  = b_sgn && b_i[W-1];
  // The magnitude of the most negative value is 2^(W-1), which still fits unsigned.
  assign a_mag  = a_neg ? -a_i : a_i;
  assign b_mag  = b_neg ? -b_i : b_i;
  // Remainder takes the dividend's sign; everything else is the xor of operand signs.
  assign neg_in = (op_i == 3'b110) ? a_neg : (a_neg ^ b_neg);

  assign b_zero = (b_i == '0);
  assign ovf    = (a_i == {1'b1, {(W-1){1'b0}}}) && (b_i == '1);
  // Only signed div/rem (op[0]=0) can overflow.
  assign fast   = op_i[2] && (b_zero || (!op_i[0] && ovf));

  always_comb begin
    fast_res = '0;
    if (b_zero) fast_res = op_i[1] ? a_i : '1;
    else        fast_res = op_i[1] ? '0  : a_i;
  end

  // ---------------- one iteration ----------------
  logic [W+B-1:0] mpart, msum;
  logic [W-1:0]   rq, qq;
  logic [W:0]     trial;
  logic [2*W-1:0] mul_nxt, div_nxt;

  always_comb begin
    // Shift-add: add multiplicand * low B multiplier bits into the high half, then shift right by B.
    mpart = '0;
    for (int i = 0; i < B; i++) begin
      if (acc[i]) mpart = mpart + ({{B{1'b0}}, opb} << i);
    end
    msum    = {{B{1'b0}}, acc[2*W-1:W]} + mpart;
    mul_nxt = {msum, acc[W-1:B]};

    // Restoring division, B quotient bits shifted in from the LSB side.
    rq    = acc[2*W-1:W];
    qq    = acc[W-1:0];
    trial = '0;
    for (int i = 0; i < B; i++) begin
      trial = {rq, qq[W-1]};
      qq    = {qq[W-2:0], 1'b0};
      if (trial >= {1'b0, opb}) begin
        trial = trial - {1'b0, opb};
        qq[0] = 1'b1;
      end
      rq = trial[W-1:0];
    end
    div_nxt = {rq, qq};
  end

  // ---------------- sign fix-up and result select ----------------
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rmd, fix_res;

  always_comb begin
    prod    = neg_q ? -acc : acc;
    quo     = neg_q ? -acc[W-1:0] : acc[W-1:0];
    rmd     = neg_q ? -acc[2*W-1:W] : acc[2*W-1:W];
    fix_res = rmd;
    case (op_q)
      3'b000:                 fix_res = prod[W-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*W-1:W];
      3'b100, 3'b101:         fix_res = quo;
      default:                fix_res = rmd;
    endcase
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = fast ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (handoff) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      opb         <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      res_o       <= '0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_o <= (state_nxt != IDLE);
      // Valid rises leaving FIX, or one edge after a fast-path entry into DONE
      // (res_o was already loaded at accept); it holds until handoff or flush.
      out_valid_o <= !flush_i && ((state == FIX) || ((state == DONE) && !handoff));
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= op_i;
            neg_q <= neg_in;
            acc   <= {{W{1'b0}}, a_mag};
            opb   <= b_mag;
            cnt   <= CNT_INIT;
            if (fast) res_o <= fast_res;
          end
        end
        CALC: begin
          acc <= op_q[2] ? div_nxt : mul_nxt;
          cnt <= cnt - CW'(1);
        end
        FIX:  res_o <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed W=32/BPC=1 checks plus a random W=16 sweep over BPC 1/2/4.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- W=32, BPC=1 instance ----------------
  logic        rst, in_valid, flush, out_ready;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        in_ready, out_valid, busy;
  logic [31:0] res;

  muldiv_unit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .a_i(a), .b_i(b), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .res_o(res), .busy_o(busy)
  );

  // ---------------- W=16 instances, BPC = 1, 2, 4 ----------------
  logic        s_rst, s_in_valid, s_flush, s_out_ready;
  logic [2:0]  s_op;
  logic [15:0] s_a, s_b;
  logic [2:0]  s_in_ready, s_out_valid, s_busy;
  logic [15:0] s_res [3];

  muldiv_unit #(.DATA_WIDTH(16), .BITS_PER_CYCLE(1)) u_s1 (
    .clk_i(clk), .rst_i(s_rst), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready[0]),
    .op_i(s_op), .a_i(s_a), .b_i(s_b), .flush_i(s_flush),
    .out_valid_o(s_out_valid[0]), .out_ready_i(s_out_ready), .res_o(s_res[0]), .busy_o(s_busy[0])
  );
  muldiv_unit #(.DATA_WIDTH(16), .BITS_PER_CYCLE(2)) u_s2 (
    .clk_i(clk), .rst_i(s_rst), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready[1]),
    .op_i(s_op), .a_i(s_a), .b_i(s_b), .flush_i(s_flush),
    .out_valid_o(s_out_valid[1]), .out_ready_i(s_out_ready), .res_o(s_res[1]), .busy_o(s_busy[1])
  );
  muldiv_unit #(.DATA_WIDTH(16), .BITS_PER_CYCLE(4)) u_s4 (
    .clk_i(clk), .rst_i(s_rst), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready[2]),
    .op_i(s_op), .a_i(s_a), .b_i(s_b), .flush_i(s_flush),
    .out_valid_o(s_out_valid[2]), .out_ready_i(s_out_ready), .res_o(s_res[2]), .busy_o(s_busy[2])
  );

  // Scoreboards: expected results pushed at drive time, popped on out_valid.
  logic [31:0] sb_q[$];
  logic [15:0] sq0[$], sq1[$], sq2[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model from wide integer arithmetic (RISC-V M semantics).
  function automatic logic [31:0] model(input int w, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          mask, sa, sb, r;
    longint unsigned ua, ub;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(x) & mask;
    ub   = longint'(y) & mask;
    sa   = x[w-1] ? (longint'(ua) - (longint'(1) << w)) : longint'(ua);
    sb   = y[w-1] ? (longint'(ub) - (longint'(1) << w)) : longint'(ub);
    case (o)
      3'd0:    r = sa * sb;
      3'd1:    r = (sa * sb) >>> w;
      3'd2:    r = (sa * longint'(ub)) >>> w;
      3'd3:    r = longint'((ua * ub) >> w);
      3'd4:    r = (ub == 0) ? -1 : sa / sb;
      3'd5:    r = (ub == 0) ? -1 : longint'(ua / ub);
      3'd6:    r = (ub == 0) ? sa : sa % sb;
      default: r = (ub == 0) ? longint'(ua) : longint'(ua % ub);
    endcase
    return 32'(r & mask);
  endfunction

  // One directed op on the W=32 unit. exp_edges counts rising edges after the accept edge
  // until out_valid is seen (N+1 normal, 1 fast path). hold = cycles of out_ready low after valid.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int exp_edges, input int hold);
    int          k;
    logic [31:0] e, held;
    @(negedge clk);
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; a = x; b = y;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom_range(7)); a = $urandom; b = $urandom;
    k = 0;
    while (k < 100) begin
      @(posedge clk); k++;
      @(negedge clk);
      if (out_valid) break;
    end
    check({tag, "_lat"}, k, exp_edges);
    e = sb_q.pop_front();
    check({tag, "_res"}, res, e);
    held = res;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      check("hold_res", res, held);
      check("hold_vld", {31'd0, out_valid}, 32'd1);
      check("hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drain"}, {29'd0, out_valid, busy, in_ready}, 32'd1);
  endtask

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    s_rst = 1'b1; s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b1; s_op = '0; s_a = '0; s_b = '0;

    // Reset values
    @(negedge clk);
    check("rst_rdy_comb", {31'd0, in_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("rst_outs", {29'd0, out_valid, busy, in_ready}, 32'd0);
    check("rst_res", res, 32'd0);
    rst = 1'b0; s_rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", {31'd0, in_ready}, 32'd1);

    // Main function, W=32 BPC=1: N=32 so valid after 33 edges (latency 34 cycles)
    run_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op("divu",   3'd5, 32'd7,         32'd2,         32'd3,         33, 0);
    run_op("remu",   3'd7, 32'd7,         32'd2,         32'd1,         33, 0);

    // Fast paths
    run_op("div0",   3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0);
    run_op("rem0",   3'd6, 32'd5,         32'd0,         32'd5,         1, 0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0);
    run_op("remu0",  3'd7, 32'd9,         32'd0,         32'd9,         1, 0);

    // Backpressure: hold 10 cycles
    run_op("bp", 3'd0, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 33, 10);

    // Flush mid-CALC
    @(negedge clk);
    in_valid = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
    sb_q.push_back(32'd14);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("flush_idle", {29'd0, out_valid, busy, in_ready}, 32'd1);
    void'(sb_q.pop_front());
    k = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) k++;
    end
    check("flush_no_vld", k, 0);
    run_op("after_flush", 3'd4, 32'd100, 32'd7, 32'd14, 33, 0);

    // Flush beats a same-cycle accept
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_vs_accept", {30'd0, busy, in_ready}, 32'd1);

    // Reset at CALC cycle 5
    @(negedge clk);
    in_valid = 1'b1; op = 3'd3; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_outs", {29'd0, out_valid, busy, in_ready}, 32'd0);
    check("midrst_res", res, 32'd0);
    rst = 1'b0;
    k = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) k++;
    end
    check("midrst_no_vld", k, 0);
    run_op("after_rst", 3'd6, 32'd100, 32'hFFFF_FFF9, 32'd2, 33, 0);

    // Random sweep at W=16 over BPC 1/2/4, all three units in lock-step
    for (int r = 0; r < 1000; r++) begin
      logic [15:0] x, y, e;
      logic [2:0]  o, done;
      logic [31:0] ex;
      logic        fst;
      int          kk;
      o = 3'($urandom_range(7));
      x = 16'($urandom);
      y = 16'($urandom);
      case ($urandom_range(7))
        0: y = 16'h0000;
        1: begin x = 16'h8000; y = 16'hFFFF; end
        2: y = 16'h0001;
        3: x = 16'h8000;
        default: ;
      endcase
      ex  = model(16, o, {16'd0, x}, {16'd0, y});
      fst = o[2] && ((y == 16'h0000) || (!o[0] && x == 16'h8000 && y == 16'hFFFF));
      @(negedge clk);
      s_in_valid = 1'b1; s_op = o; s_a = x; s_b = y;
      sq0.push_back(ex[15:0]); sq1.push_back(ex[15:0]); sq2.push_back(ex[15:0]);
      @(posedge clk); #1;
      s_in_valid = 1'b0; s_a = 16'($urandom); s_b = 16'($urandom);
      done = 3'b000;
      kk = 0;
      while (done != 3'b111 && kk < 40) begin
        @(posedge clk); kk++;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          if (!done[i] && s_out_valid[i]) begin
            case (i)
              0:       e = sq0.pop_front();
              1:       e = sq1.pop_front();
              default: e = sq2.pop_front();
            endcase
            check("sweep_res", {16'd0, s_res[i]}, {16'd0, e});
            check("sweep_lat", kk, fst ? 1 : (16 >> i) + 1);
            done[i] = 1'b1;
          end
        end
      end
      check("sweep_done", {29'd0, done}, 32'd7);
      sq0.delete(); sq1.delete(); sq2.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
